// File: rtl/bp_me_pkg.sv
// Shared types for the cache-slice backing memory: the bedrock memory header,
// the message enums it carries, and the DMA memory FSM state encoding.
package bp_me_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int paddr_width_p       = 40;
  localparam int cce_block_width_p   = 512;
  localparam int mem_payload_width_p = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [mem_payload_width_p-1:0] payload;
    logic                           amo_no_return;
    bp_bedrock_msg_size_e           size;
    logic [paddr_width_p-1:0]       addr;
    bp_bedrock_mem_type_e           msg_type;
  } bp_bedrock_mem_header_s;

  localparam int cce_mem_msg_header_width_lp = $bits(bp_bedrock_mem_header_s);

  typedef enum logic [2:0] {
    e_ready    = 3'd0,
    e_wr_data  = 3'd1,
    e_rd_wait  = 3'd2,
    e_rd_read  = 3'd3,
    e_resp_hdr = 3'd4,
    e_rd_data  = 3'd5
  } bp_me_dma_mem_state_e;

  // Block width per processor configuration; only the default config exists today.
  function automatic int cfg_block_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return cce_block_width_p;
      default:          return cce_block_width_p;
    endcase
  endfunction

  function automatic bp_bedrock_mem_header_s resp_header(input bp_bedrock_mem_header_s cmd);
    bp_bedrock_mem_header_s r;
    r = cmd;
    r.amo_no_return = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/bp_me_cache_dma_mem_if.sv
// Command/response bundle between a cache slice's DMA side (master) and its
// backing memory (slave): headers plus data beats, each with its own handshake.
interface bp_me_cache_dma_mem_if
  import bp_me_pkg::*;
 #(parameter int data_width_p = 64)
  ();

  bp_bedrock_mem_header_s  mem_cmd_header_i;
  logic                    mem_cmd_header_v_i;
  logic                    mem_cmd_header_yumi_o;
  logic [data_width_p-1:0] mem_cmd_data_i;
  logic                    mem_cmd_data_v_i;
  logic                    mem_cmd_data_yumi_o;

  bp_bedrock_mem_header_s  mem_resp_header_o;
  logic                    mem_resp_header_v_o;
  logic                    mem_resp_header_ready_and_i;
  logic [data_width_p-1:0] mem_resp_data_o;
  logic                    mem_resp_data_v_o;
  logic                    mem_resp_data_ready_and_i;

  modport slave (
    input  mem_cmd_header_i,
    input  mem_cmd_header_v_i,
    output mem_cmd_header_yumi_o,
    input  mem_cmd_data_i,
    input  mem_cmd_data_v_i,
    output mem_cmd_data_yumi_o,
    output mem_resp_header_o,
    output mem_resp_header_v_o,
    input  mem_resp_header_ready_and_i,
    output mem_resp_data_o,
    output mem_resp_data_v_o,
    input  mem_resp_data_ready_and_i
  );

  modport master (
    output mem_cmd_header_i,
    output mem_cmd_header_v_i,
    input  mem_cmd_header_yumi_o,
    output mem_cmd_data_i,
    output mem_cmd_data_v_i,
    input  mem_cmd_data_yumi_o,
    input  mem_resp_header_o,
    input  mem_resp_header_v_o,
    output mem_resp_header_ready_and_i,
    input  mem_resp_data_o,
    input  mem_resp_data_v_o,
    output mem_resp_data_ready_and_i
  );

endinterface

// File: rtl/bp_me_cache_dma_mem_sram.sv
// Single-port synchronous SRAM: one read or write per cycle, read data appears
// the cycle after the request and holds until the next read.
module bsg_mem_1rw_sync
 #(parameter int width_p      = 64,
   parameter int els_p        = 8192,
   parameter int addr_width_p = $clog2(els_p))
  (input  logic                    clk_i,
   input  logic                    v_i,
   input  logic                    w_i,
   input  logic [addr_width_p-1:0] addr_i,
   input  logic [width_p-1:0]      data_i,
   output logic [width_p-1:0]      data_o);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] data_q;

  // Storage is deliberately unreset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (v_i) begin
      if (w_i) begin
        mem_q[addr_i] <= data_i;
      end else begin
        data_q <= mem_q[addr_i];
      end
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bp_me_cache_dma_mem.sv
// Backing memory behind a cache slice's DMA port: accepts one block read or
// write at a time and answers with a response header plus read beats.
module bp_me_cache_dma_mem
  import bp_me_pkg::*;
 #(parameter bp_params_e bp_params_p    = e_bp_default_cfg,
   parameter int         data_width_p   = 64,
   parameter int         mem_blocks_p   = 1024,
   parameter int         read_latency_p = 4)
  (input  logic                   clk_i,
   input  logic                   reset_n_i,
   bp_me_cache_dma_mem_if.slave   mem_if);

  localparam int block_width_lp     = cfg_block_width(bp_params_p);
  localparam int beats_lp           = block_width_lp / data_width_p;
  localparam int lg_beats_lp        = $clog2(beats_lp);
  localparam int lg_mem_blocks_lp   = $clog2(mem_blocks_p);
  localparam int block_offset_lp    = $clog2(block_width_lp / 8);
  localparam int sram_els_lp        = mem_blocks_p * beats_lp;
  localparam int sram_addr_width_lp = lg_mem_blocks_lp + lg_beats_lp;
  localparam int lat_width_lp       = (read_latency_p > 1) ? $clog2(read_latency_p) : 1;

  localparam logic [lg_beats_lp-1:0]  last_beat_lp = lg_beats_lp'(beats_lp - 1);
  localparam logic [lat_width_lp-1:0] lat_last_lp  =
    lat_width_lp'((read_latency_p > 0) ? (read_latency_p - 1) : 0);

  bp_me_dma_mem_state_e   state_q;
  bp_bedrock_mem_header_s header_q;
  logic [lg_beats_lp-1:0] beat_cnt_q;
  logic [lat_width_lp-1:0] lat_cnt_q;
  logic                   resp_header_v_q;
  logic                   resp_data_v_q;

  logic                   header_yumi;
  logic                   data_yumi;
  logic                   is_wr_cmd;
  logic                   is_wr_q;
  logic                   last_beat;

  logic                          sram_v;
  logic                          sram_w;
  logic [lg_beats_lp-1:0]        sram_beat;
  logic [sram_addr_width_lp-1:0] sram_addr;
  logic [data_width_p-1:0]       sram_data_lo;

  // Yumis follow valid combinationally but are suppressed during reset.
  assign header_yumi = reset_n_i & (state_q == e_ready) & mem_if.mem_cmd_header_v_i;
  assign data_yumi   = reset_n_i & (state_q == e_wr_data) & mem_if.mem_cmd_data_v_i;
  assign is_wr_cmd   = (mem_if.mem_cmd_header_i.msg_type == e_bedrock_mem_wr);
  assign is_wr_q     = (header_q.msg_type == e_bedrock_mem_wr);
  assign last_beat   = (beat_cnt_q == last_beat_lp);

  assign mem_if.mem_cmd_header_yumi_o = header_yumi;
  assign mem_if.mem_cmd_data_yumi_o   = data_yumi;
  assign mem_if.mem_resp_header_o     = header_q;
  assign mem_if.mem_resp_header_v_o   = resp_header_v_q;
  assign mem_if.mem_resp_data_o       = sram_data_lo;
  assign mem_if.mem_resp_data_v_o     = resp_data_v_q;

  // A read-data handshake prefetches the following word so beats stream back to back.
  always_comb begin
    sram_v    = 1'b0;
    sram_w    = 1'b0;
    sram_beat = beat_cnt_q;
    case (state_q)
      e_wr_data: begin
        sram_v = data_yumi;
        sram_w = 1'b1;
      end
      e_rd_read: begin
        sram_v = 1'b1;
      end
      e_rd_data: begin
        sram_v    = mem_if.mem_resp_data_ready_and_i & ~last_beat;
        sram_beat = beat_cnt_q + 1'b1;
      end
      default: begin
        sram_v = 1'b0;
      end
    endcase
  end

  assign sram_addr = {header_q.addr[block_offset_lp +: lg_mem_blocks_lp], sram_beat};

  bsg_mem_1rw_sync
   #(.width_p(data_width_p),
     .els_p(sram_els_lp),
     .addr_width_p(sram_addr_width_lp))
   mem
    (.clk_i(clk_i),
     .v_i(sram_v),
     .w_i(sram_w),
     .addr_i(sram_addr),
     .data_i(mem_if.mem_cmd_data_i),
     .data_o(sram_data_lo));

  // Control FSM; response valids are registered alongside the state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q         <= e_ready;
      header_q        <= '0;
      beat_cnt_q      <= '0;
      lat_cnt_q       <= '0;
      resp_header_v_q <= 1'b0;
      resp_data_v_q   <= 1'b0;
    end else begin
      case (state_q)
        e_ready: begin
          if (header_yumi) begin
            header_q <= resp_header(mem_if.mem_cmd_header_i);
            if (is_wr_cmd) begin
              state_q <= e_wr_data;
            end else if (read_latency_p > 0) begin
              state_q <= e_rd_wait;
            end else begin
              state_q <= e_rd_read;
            end
          end
        end
        e_wr_data: begin
          if (data_yumi) begin
            if (last_beat) begin
              beat_cnt_q      <= '0;
              resp_header_v_q <= 1'b1;
              state_q         <= e_resp_hdr;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        e_rd_wait: begin
          if (lat_cnt_q == lat_last_lp) begin
            lat_cnt_q <= '0;
            state_q   <= e_rd_read;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        e_rd_read: begin
          resp_header_v_q <= 1'b1;
          state_q         <= e_resp_hdr;
        end
        e_resp_hdr: begin
          if (mem_if.mem_resp_header_ready_and_i) begin
            resp_header_v_q <= 1'b0;
            if (is_wr_q) begin
              state_q <= e_ready;
            end else begin
              resp_data_v_q <= 1'b1;
              state_q       <= e_rd_data;
            end
          end
        end
        e_rd_data: begin
          if (mem_if.mem_resp_data_ready_and_i) begin
            if (last_beat) begin
              beat_cnt_q    <= '0;
              resp_data_v_q <= 1'b0;
              state_q       <= e_ready;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= e_ready;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_me_cache_dma_mem.sv
// Directed-plus-random bench for bp_me_cache_dma_mem, checked against a
// word-indexed memory model with aliasing computed from the address.
module tb_bp_me_cache_dma_mem;
  import bp_me_pkg::*;

  localparam int dataWidth   = 64;
  localparam int memBlocks   = 1024;
  localparam int readLatency = 4;
  localparam int beats       = 8;

  typedef logic [63:0] block_t [beats];

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int cycleCnt = 0;
  int checks = 0;
  int errors = 0;
  logic [63:0] refMem [longint];
  logic [39:0] written [$];

  bp_me_cache_dma_mem_if #(.data_width_p(dataWidth)) mem_if ();

  bp_me_cache_dma_mem
   #(.bp_params_p(e_bp_default_cfg),
     .data_width_p(dataWidth),
     .mem_blocks_p(memBlocks),
     .read_latency_p(readLatency))
   dut
    (.clk_i(clk),
     .reset_n_i(rstN),
     .mem_if(mem_if));

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no end, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Memory model: block index wraps modulo the number of stored blocks.
  function automatic longint wordIdx(input logic [39:0] addr, input int beat);
    longint a;
    a = longint'(addr);
    return ((a / 64) % memBlocks) * beats + beat;
  endfunction

  function automatic void modelWrite(input logic [39:0] addr, input block_t d);
    for (int i = 0; i < beats; i++) refMem[wordIdx(addr, i)] = d[i];
  endfunction

  function automatic block_t modelRead(input logic [39:0] addr);
    block_t r;
    for (int i = 0; i < beats; i++) r[i] = refMem[wordIdx(addr, i)];
    return r;
  endfunction

  function automatic bp_bedrock_mem_header_s mkHdr(input bp_bedrock_mem_type_e t, input logic [39:0] addr,
                                                   input logic [15:0] pay, input logic amo);
    bp_bedrock_mem_header_s h;
    h.msg_type      = t;
    h.addr          = addr;
    h.size          = e_bedrock_msg_size_64;
    h.payload       = pay;
    h.amo_no_return = amo;
    return h;
  endfunction

  function automatic bp_bedrock_mem_header_s expHdr(input bp_bedrock_mem_header_s h);
    bp_bedrock_mem_header_s e;
    e = h;
    e.amo_no_return = 1'b0;
    return e;
  endfunction

  function automatic block_t randBlock();
    block_t d;
    for (int i = 0; i < beats; i++) d[i] = {$urandom, $urandom};
    return d;
  endfunction

  task automatic applyStimulus(input bp_bedrock_mem_header_s hdr, input logic withData,
                               input logic [63:0] firstBeat, output int acceptCycle);
    int n;
    n = 0;
    @(negedge clk);
    mem_if.mem_cmd_header_i   = hdr;
    mem_if.mem_cmd_header_v_i = 1'b1;
    mem_if.mem_cmd_data_i     = firstBeat;
    mem_if.mem_cmd_data_v_i   = withData;
    #1;
    while (!mem_if.mem_cmd_header_yumi_o && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("cmd_hdr_yumi", mem_if.mem_cmd_header_yumi_o, 1'b1);
    if (withData) checkOutput("data_yumi_in_ready", mem_if.mem_cmd_data_yumi_o, 1'b0);
    acceptCycle = cycleCnt;
    @(posedge clk);
    #1;
    mem_if.mem_cmd_header_v_i = 1'b0;
  endtask

  task automatic sendBeats(input block_t d, input int gap);
    int n;
    for (int i = 0; i < beats; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        mem_if.mem_cmd_data_v_i = 1'b0;
        mem_if.mem_cmd_data_i   = {$urandom, $urandom};
        #1;
        checkOutput("data_yumi_idle", mem_if.mem_cmd_data_yumi_o, 1'b0);
      end
      n = 0;
      @(negedge clk);
      mem_if.mem_cmd_data_i   = d[i];
      mem_if.mem_cmd_data_v_i = 1'b1;
      #1;
      while (!mem_if.mem_cmd_data_yumi_o && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      checkOutput("data_yumi", mem_if.mem_cmd_data_yumi_o, 1'b1);
      @(posedge clk);
      #1;
      mem_if.mem_cmd_data_v_i = 1'b0;
    end
  endtask

  task automatic recvHeader(input bp_bedrock_mem_header_s exp, input int stall, input int expCycle);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (!mem_if.mem_resp_header_v_o && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("resp_hdr_v", mem_if.mem_resp_header_v_o, 1'b1);
    if (expCycle >= 0) checkOutput("resp_hdr_cycle", cycleCnt, expCycle);
    checkOutput("resp_hdr", mem_if.mem_resp_header_o, exp);
    checkOutput("resp_data_v_before_hdr", mem_if.mem_resp_data_v_o, 1'b0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      checkOutput("resp_hdr_hold_v", mem_if.mem_resp_header_v_o, 1'b1);
      checkOutput("resp_hdr_hold", mem_if.mem_resp_header_o, exp);
    end
    mem_if.mem_resp_header_ready_and_i = 1'b1;
    @(posedge clk);
    #1;
    mem_if.mem_resp_header_ready_and_i = 1'b0;
  endtask

  task automatic recvBeats(input block_t exp, input int toggle, input int firstCycle, input int count);
    int n;
    for (int i = 0; i < count; i++) begin
      n = 0;
      @(negedge clk);
      #1;
      while (!mem_if.mem_resp_data_v_o && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      checkOutput("resp_data_v", mem_if.mem_resp_data_v_o, 1'b1);
      checkOutput($sformatf("resp_beat%0d", i), mem_if.mem_resp_data_o, exp[i]);
      if (firstCycle >= 0) checkOutput("resp_beat_cycle", cycleCnt, firstCycle + i);
      if (toggle != 0) begin
        mem_if.mem_resp_data_ready_and_i = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("resp_beat_hold_v", mem_if.mem_resp_data_v_o, 1'b1);
        checkOutput($sformatf("resp_beat%0d_hold", i), mem_if.mem_resp_data_o, exp[i]);
      end
      mem_if.mem_resp_data_ready_and_i = 1'b1;
      @(posedge clk);
      #1;
      mem_if.mem_resp_data_ready_and_i = 1'b0;
    end
  endtask

  task automatic expectIdle(input string tag);
    @(negedge clk);
    #1;
    checkOutput(tag, {mem_if.mem_resp_header_v_o, mem_if.mem_resp_data_v_o}, 2'b00);
  endtask

  task automatic doWrite(input logic [39:0] addr, input block_t d, input int gap);
    bp_bedrock_mem_header_s h;
    int acc;
    h = mkHdr(e_bedrock_mem_wr, addr, 16'($urandom), 1'($urandom));
    applyStimulus(h, 1'b0, 64'h0, acc);
    sendBeats(d, gap);
    modelWrite(addr, d);
    written.push_back(addr);
    recvHeader(expHdr(h), 0, -1);
    expectIdle("wr_no_data");
  endtask

  task automatic doRead(input bp_bedrock_mem_type_e t, input logic [39:0] addr, input int toggle);
    bp_bedrock_mem_header_s h;
    int acc;
    h = mkHdr(t, addr, 16'($urandom), 1'($urandom));
    applyStimulus(h, 1'b0, 64'h0, acc);
    recvHeader(expHdr(h), 0, -1);
    recvBeats(modelRead(addr), toggle, -1, beats);
    expectIdle("rd_drained");
  endtask

  initial begin
    block_t d;
    bp_bedrock_mem_header_s h;
    logic [39:0] a;
    int acc;

    mem_if.mem_cmd_header_i            = '0;
    mem_if.mem_cmd_header_v_i          = 1'b1;
    mem_if.mem_cmd_data_i              = '0;
    mem_if.mem_cmd_data_v_i            = 1'b1;
    mem_if.mem_resp_header_ready_and_i = 1'b0;
    mem_if.mem_resp_data_ready_and_i   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_outputs",
                {mem_if.mem_resp_header_v_o, mem_if.mem_resp_data_v_o,
                 mem_if.mem_cmd_header_yumi_o, mem_if.mem_cmd_data_yumi_o}, 4'b0000);
    mem_if.mem_cmd_header_v_i = 1'b0;
    mem_if.mem_cmd_data_v_i   = 1'b0;
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] directed write 0x8000_0040 with data valid alongside header");
    for (int i = 0; i < beats; i++) d[i] = 64'h11 + 64'(i);
    h = mkHdr(e_bedrock_mem_wr, 40'h00_8000_0040, 16'h1234, 1'b1);
    applyStimulus(h, 1'b1, d[0], acc);
    sendBeats(d, 0);
    modelWrite(h.addr, d);
    written.push_back(h.addr);
    recvHeader(expHdr(h), 2, -1);
    expectIdle("wr_no_data");

    $display("[TB] readback with latency timing");
    h = mkHdr(e_bedrock_mem_rd, 40'h00_8000_0040, 16'h0abc, 1'b0);
    applyStimulus(h, 1'b0, 64'h0, acc);
    recvHeader(expHdr(h), 0, acc + readLatency + 2);
    recvBeats(modelRead(h.addr), 0, acc + readLatency + 3, beats);
    expectIdle("rd_drained");

    $display("[TB] gapped write then toggled-ready read");
    a = {8'($urandom), 32'($urandom)};
    a[5:0] = 6'h0;
    doWrite(a, randBlock(), 2);
    doRead(e_bedrock_mem_rd, a, 1);

    $display("[TB] aliasing");
    doWrite(40'h40, randBlock(), 0);
    doWrite(40'h40 + 40'(memBlocks * 64), randBlock(), 1);
    doRead(e_bedrock_mem_rd, 40'h40, 0);

    $display("[TB] uncached read type treated as read");
    doRead(e_bedrock_mem_uc_rd, 40'h00_8000_0040, 0);

    $display("[TB] random traffic");
    for (int k = 0; k < 5; k++) begin
      a = {8'($urandom), 32'($urandom)};
      a[5:0] = 6'h0;
      doWrite(a, randBlock(), int'($urandom_range(0, 2)));
      doRead(e_bedrock_mem_rd, written[$urandom_range(0, written.size() - 1)], int'($urandom_range(0, 1)));
    end

    $display("[TB] reset mid-read");
    h = mkHdr(e_bedrock_mem_rd, 40'h00_8000_0040, 16'h5555, 1'b0);
    applyStimulus(h, 1'b0, 64'h0, acc);
    recvHeader(expHdr(h), 0, -1);
    recvBeats(modelRead(h.addr), 0, -1, 3);
    mem_if.mem_cmd_header_i   = mkHdr(e_bedrock_mem_rd, 40'h40, 16'h0, 1'b0);
    mem_if.mem_cmd_header_v_i = 1'b1;
    rstN = 1'b0;
    #1;
    checkOutput("mid_reset_outputs",
                {mem_if.mem_resp_header_v_o, mem_if.mem_resp_data_v_o,
                 mem_if.mem_cmd_header_yumi_o}, 3'b000);
    @(negedge clk);
    mem_if.mem_cmd_header_v_i = 1'b0;
    rstN = 1'b1;
    expectIdle("post_reset_idle");
    doRead(e_bedrock_mem_rd, 40'h40, 0);
    doRead(e_bedrock_mem_rd, 40'h00_8000_0040, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_me_cache_dma_mem.md
Name: bp_me_cache_dma_mem

Overview:
- Backing-memory endpoint directly downstream of the L2 cache slice's DMA side.
- Consumes the slice's mem_cmd header stream plus dword data beats, services block reads/writes against an internal word-addressed SRAM, and returns a mem_resp header stream plus read data beats.
- Used as the simulation/FPGA memory behind each cache slice; one outstanding command at a time.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, cce_block_width_p and the bedrock header width.
- data_width_p, 64 (dword_width_gp), beat width.
- mem_blocks_p, 1024, number of blocks stored; power of two.
- read_latency_p, 4, extra idle cycles between read command accept and response header; 0 is legal.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- mem_cmd_header_i  in  cce_mem_msg_header_width_lp  bedrock header; msg_type e_bedrock_mem_rd/wr, addr block-aligned.
- mem_cmd_header_v_i  in  1  header valid.
- mem_cmd_header_yumi_o  out  1  header consumed.
- mem_cmd_data_i  in  data_width_p  write beat.
- mem_cmd_data_v_i  in  1  beat valid.
- mem_cmd_data_yumi_o  out  1  beat consumed.
- mem_resp_header_o  out  cce_mem_msg_header_width_lp  response header.
- mem_resp_header_v_o  out  1  response header valid.
- mem_resp_header_ready_and_i  in  1  downstream accepts header.
- mem_resp_data_o  out  data_width_p  read beat.
- mem_resp_data_v_o  out  1  read beat valid.
- mem_resp_data_ready_and_i  in  1  downstream accepts beat.

Behaviour:
- Constants: beats_lp = cce_block_width_p/data_width_p; SRAM depth = mem_blocks_p*beats_lp words of data_width_p; word index = {addr block-index bits (mod mem_blocks_p), beat_cnt}. Upper address bits are ignored, so out-of-range addresses alias.
- Reset (reset_n_i low, asynchronous): state=e_ready, beat_cnt=0, lat_cnt=0. All v_o and yumi_o outputs are 0 while in reset. SRAM contents are not reset. Reset mid-transaction abandons it; no partial response is produced.
- e_ready:
  - mem_cmd_header_yumi_o = mem_cmd_header_v_i.
  - On a yumi, latch the header (msg_type, addr, size, payload).
  - wr -> e_wr_data; rd -> e_rd_wait when read_latency_p>0, else e_rd_read.
  - Any other msg_type is treated as rd.
- e_wr_data:
  - mem_cmd_data_yumi_o = mem_cmd_data_v_i.
  - Each yumi writes the beat to the SRAM at word (block, beat_cnt) and increments beat_cnt.
  - On the last beat (beat_cnt==beats_lp-1): beat_cnt wraps to 0, then -> e_resp_hdr.
  - Beats arriving outside e_wr_data are not consumed.
- e_rd_wait: lat_cnt counts 0..read_latency_p-1, then -> e_rd_read.
- e_rd_read: issue the synchronous SRAM read of word (block, beat_cnt), then -> e_resp_hdr. Data appears the next cycle and is held in a one-entry output register.
- e_resp_hdr:
  - mem_resp_header_v_o=1.
  - Header echoes the latched msg_type, size, addr and payload; amo_no_return=0.
  - Header is stable until mem_resp_header_ready_and_i.
  - On the handshake: wr -> e_ready; rd -> e_rd_data.
- e_rd_data:
  - mem_resp_data_v_o=1 with the registered beat.
  - On a handshake: increment beat_cnt and issue the SRAM read of the next word in the same cycle, so the next beat is valid the following cycle (back-to-back beats).
  - Data is held stable while ready_and is low.
  - After the last beat: beat_cnt=0, -> e_ready.
- Minimum read latency (ready_and held high, read_latency_p=4): header accept -> response header valid after 6 cycles; beats follow one per cycle.
- Ordering: the response header always precedes the first data beat. At most one command is in flight, so no header is accepted until the previous response fully drains.
- Write responses carry no data beats.
- Simultaneous header and data valid in e_ready: only the header is consumed that cycle.

Decomposition:
- Shared package bp_me_pkg: state enum bp_me_dma_mem_state_e {e_ready, e_wr_data, e_rd_wait, e_rd_read, e_resp_hdr, e_rd_data}.
- Header struct from the existing bedrock mem-if macros.
- Sub-module: bsg_mem_1rw_sync (width data_width_p, els mem_blocks_p*beats_lp) for storage.
- Control FSM, counters and output register stay in this module.

Test Plan:
- Write addr 0x8000_0040, beats 0x11..0x18 (512b block), then read same addr -> wr resp header with msg_type wr, no data; rd resp header addr 0x8000_0040 then beats 0x11..0x18 in order.
- read_latency_p=4, ready_and always 1, read cmd at cycle 10 -> resp header valid cycle 16, beats cycles 17-24 contiguous.
- Read with mem_resp_data_ready_and_i toggling 1/0 each cycle -> every beat is held stable while stalled; no beat is duplicated or dropped; total 8 beats.
- Write beats with data_v_i gaps (valid every 3rd cycle) -> header/data yumi only on valid; readback matches.
- Assert reset_n_i low mid-read after the 3rd beat, release -> outputs v=0 immediately; next header is accepted in e_ready; previously written data is still readable.
- Write addr 0x40 and addr 0x40+mem_blocks_p*64 (aliasing) -> readback of 0x40 returns the second write's data.
